press_generator: RTL and testbench

PRESS_GENERATOR -- requirements
Module: press_generator

---
 rtl/press_generator.sv | 125 ++++++++++++
 tb/tb_press_generator.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/press_generator.sv
// press_generator: emulates an active-low push button. Each request produces a timed press followed by a release gap.
// Optional macro PRESS_BOUNCE_EN adds a 0,1,0,1 contact-bounce pattern at the start of every press.
`default_nettype none

module press_generator #(
    parameter int PRESS_CYCLES = 8,
    parameter int GAP_CYCLES   = 4,
    parameter int MAX_PENDING  = 3
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       req_i,
    output logic       button_no,
    output logic       busy_o,
    output logic [3:0] pending_o,
    output logic       done_o,
    output logic       drop_o
);

    localparam logic [7:0] PRESS_LOAD = 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] GAP_LOAD   = 8'(GAP_CYCLES - 1);
    localparam logic [3:0] PEND_MAX   = 4'(MAX_PENDING);
`ifdef PRESS_BOUNCE_EN
    // Counter values in press cycles 0 and 2; the following cycle bounces high.
    localparam logic [7:0] BOUNCE_A   = 8'(PRESS_CYCLES - 1);
    localparam logic [7:0] BOUNCE_B   = 8'(PRESS_CYCLES - 3);
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRESS = 2'd1,
        GAP   = 2'd2
    } state_t;

    state_t     state;
    logic [7:0] cnt;
    logic [3:0] pending;

    logic is_idle;
    logic gap_end;
    logic consume;
    logic inc;
    logic dec;

    // A request arriving in IDLE with nothing queued starts the press itself.
    always_comb begin
        is_idle = (state == IDLE);
        gap_end = (state == GAP) && (cnt == 8'd0);
        consume = is_idle && (pending == 4'd0) && req_i;
        inc     = req_i && !consume;
        dec     = (is_idle && (pending != 4'd0)) ||
                  (gap_end && ((pending != 4'd0) || inc));
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state     <= IDLE;
            cnt       <= 8'd0;
            pending   <= 4'd0;
            button_no <= 1'b1;
            done_o    <= 1'b0;
            drop_o    <= 1'b0;
        end else begin
            done_o <= 1'b0;
            drop_o <= 1'b0;

            if (inc && !dec) begin
                if (pending == PEND_MAX) begin
                    drop_o <= 1'b1;
                end else begin
                    pending <= pending + 4'd1;
                end
            end else if (dec && !inc) begin
                pending <= pending - 4'd1;
            end

            case (state)
                IDLE: begin
                    if (req_i || (pending != 4'd0)) begin
                        state     <= PRESS;
                        cnt       <= PRESS_LOAD;
                        button_no <= 1'b0;
                    end
                end
                PRESS: begin
                    if (cnt == 8'd0) begin
                        state     <= GAP;
                        cnt       <= GAP_LOAD;
                        button_no <= 1'b1;
                        done_o    <= 1'b1;
                    end else begin
                        cnt <= cnt - 8'd1;
`ifdef PRESS_BOUNCE_EN
                        button_no <= (cnt == BOUNCE_A) || (cnt == BOUNCE_B);
`endif
                    end
                end
                GAP: begin
                    if (cnt == 8'd0) begin
                        if (dec) begin
                            state     <= PRESS;
                            cnt       <= PRESS_LOAD;
                            button_no <= 1'b0;
                        end else begin
                            state <= IDLE;
                        end
                    end else begin
                        cnt <= cnt - 8'd1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= 8'd0;
                    button_no <= 1'b1;
                end
            endcase
        end
    end

    assign busy_o    = (state != IDLE);
    assign pending_o = pending;

endmodule

`default_nettype wire

// File: tb/tb_press_generator.sv
// tb_press_generator: directed and random requests checked against a timeline model of press windows.
`default_nettype none

module tb_press_generator;

    localparam int P    = 8;
    localparam int G    = 4;
    localparam int MAXP = 3;
`ifdef PRESS_BOUNCE_EN
    localparam int LOWS_PER_PRESS  = P - 2;
    localparam int FALLS_PER_PRESS = 3;
`else
    localparam int LOWS_PER_PRESS  = P;
    localparam int FALLS_PER_PRESS = 1;
`endif

    logic       clk_i  = 1'b0;
    logic       rst_ni = 1'b0;
    logic       req_i  = 1'b0;
    logic       button_no;
    logic       busy_o;
    logic [3:0] pending_o;
    logic       done_o;
    logic       drop_o;

    press_generator #(
        .PRESS_CYCLES(P),
        .GAP_CYCLES  (G),
        .MAX_PENDING (MAXP)
    ) dut (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .req_i    (req_i),
        .button_no(button_no),
        .busy_o   (busy_o),
        .pending_o(pending_o),
        .done_o   (done_o),
        .drop_o   (drop_o)
    );

    always #5 clk_i = ~clk_i;

    int checks   = 0;
    int failures = 0;

    // Model: start cycle of the most recent press plus the queue depth.
    int t         = 0;
    int cur_start = -1000;
    int m_pend    = 0;
    bit m_drop    = 1'b0;

    bit prev_btn = 1'b1;
    int falls    = 0;
    int lows     = 0;
    int dones    = 0;
    int drops    = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d (t=%0d)", tag, obs, exp, t);
        end
    endtask

    function automatic logic press_level(input int k);
`ifdef PRESS_BOUNCE_EN
        return (k == 1) || (k == 3);
`else
        return 1'b0;
`endif
    endfunction

    task automatic model_reset();
        t         = 0;
        cur_start = -1000;
        m_pend    = 0;
        m_drop    = 1'b0;
    endtask

    task automatic model_update(input bit r);
        int pe;
        bit active, gap_end, consume, inc, dec;
        pe      = cur_start + P + G - 1;
        active  = (t >= cur_start) && (t <= pe);
        gap_end = active && (t == pe);
        consume = !active && (m_pend == 0) && r;
        inc     = r && !consume;
        dec     = (!active && (m_pend > 0)) || (gap_end && ((m_pend > 0) || inc));
        m_drop  = inc && !dec && (m_pend == MAXP);
        if (inc && !dec && !m_drop) m_pend++;
        else if (dec && !inc)       m_pend--;
        if (consume || dec) cur_start = t + 1;
    endtask

    // Called mid-cycle (at negedge): check this cycle's outputs, then drive req for it.
    task automatic step(input bit r);
        int k;
        k = t - cur_start;
        chk("button", 32'(button_no), (k >= 0 && k < P) ? 32'(press_level(k)) : 32'd1);
        chk("busy",   32'(busy_o),    32'(k >= 0 && k < P + G));
        chk("pending",32'(pending_o), 32'(m_pend));
        chk("done",   32'(done_o),    32'(k == P));
        chk("drop",   32'(drop_o),    32'(m_drop));
        if (prev_btn && !button_no) falls++;
        prev_btn = button_no;
        if (!button_no) lows++;
        if (done_o)     dones++;
        if (drop_o)     drops++;
        req_i = r;
        if (rst_ni) model_update(r);
        t++;
        @(negedge clk_i);
    endtask

    task automatic clear_counts();
        falls = 0; lows = 0; dones = 0; drops = 0;
    endtask

    initial begin
        model_reset();
        @(negedge clk_i);
        step(1'b0);
        step(1'b1);
        step(1'b0);

        rst_ni = 1'b1;
        model_reset();
        // Request in the very first cycle after release.
        clear_counts();
        step(1'b1);
        repeat (20) step(1'b0);
        chk("first_after_reset_presses", 32'(falls), 32'(FALLS_PER_PRESS));

        // Single request timing.
        repeat (10) step(1'b0);
        clear_counts();
        step(1'b1);
        repeat (20) step(1'b0);
        chk("single_low_cycles", 32'(lows), 32'(LOWS_PER_PRESS));
        chk("single_done_count", 32'(dones), 32'd1);
        chk("loopback_falls", 32'(falls), 32'(FALLS_PER_PRESS));

        // Back-to-back requests at 0, 2, 4.
        clear_counts();
        step(1'b1); step(1'b0); step(1'b1); step(1'b0); step(1'b1);
        repeat (40) step(1'b0);
        chk("b2b_falls", 32'(falls), 32'(3 * FALLS_PER_PRESS));
        chk("b2b_drops", 32'(drops), 32'd0);
        chk("b2b_dones", 32'(dones), 32'd3);

        // Overflow: five requests, the first starting the press.
        clear_counts();
        repeat (5) step(1'b1);
        repeat (60) step(1'b0);
        chk("ovf_drops", 32'(drops), 32'd1);
        chk("ovf_falls", 32'(falls), 32'(4 * FALLS_PER_PRESS));

        // Request in the final gap cycle with a full queue.
        clear_counts();
        step(1'b1); step(1'b0);
        repeat (3) step(1'b1);
        repeat (7) step(1'b0);
        step(1'b1);
        chk("simul_pending", 32'(pending_o), 32'd3);
        chk("simul_drop", 32'(drop_o), 32'd0);
        chk("simul_new_press", 32'(button_no), 32'd0);
        repeat (60) step(1'b0);
        chk("simul_drops_total", 32'(drops), 32'd0);

        // Random traffic.
        repeat (400) step($urandom_range(0, 7) == 0);
        repeat (60) step(1'b0);

        // Asynchronous reset in the middle of a press with a queued request.
        step(1'b1); step(1'b1);
        repeat (3) step(1'b0);
        #2 rst_ni = 1'b0;
        #1;
        chk("rst_async_button", 32'(button_no), 32'd1);
        chk("rst_async_pending", 32'(pending_o), 32'd0);
        chk("rst_async_busy", 32'(busy_o), 32'd0);
        model_reset();
        prev_btn = button_no;
        clear_counts();
        @(negedge clk_i);
        step(1'b0); step(1'b0);
        rst_ni = 1'b1;
        model_reset();
        repeat (20) step(1'b0);
        chk("rst_no_done", 32'(dones), 32'd0);
        step(1'b1);
        repeat (20) step(1'b0);
        chk("rst_fresh_low_cycles", 32'(lows), 32'(LOWS_PER_PRESS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
